sensor_input_conditioner: RTL and testbench



---
 rtl/sensor_input_conditioner.sv | 212 +++++++++++++++++++++
 tb/tb_sensor_input_conditioner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_input_conditioner.sv
// Irrigation front end: synchronises and debounces sensor and selector pins, then filters water-level faults.
// Optional macro SELECTOR_REPEAT_EN makes a held selector re-fire its pulse every 4*DEBOUNCE_COUNT ticks.
module sensor_input_conditioner #(
  parameter int SAMPLE_DIV     = 50000,
  parameter int DEBOUNCE_COUNT = 4,
  parameter int FAULT_HOLD     = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic low_water_level_raw,
  input  logic mid_water_level_raw,
  input  logic high_water_level_raw,
  input  logic earth_humidity_raw,
  input  logic air_humidity_raw,
  input  logic low_temperature_raw,
  input  logic selector_raw,
  output logic low_water_level,
  output logic mid_water_level,
  output logic high_water_level,
  output logic earth_humidity,
  output logic air_humidity,
  output logic low_temperature,
  output logic selector_pulse,
  output logic sensor_changed,
  output logic water_fault
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int DW = $clog2(DEBOUNCE_COUNT + 1);
  localparam int HW = $clog2(FAULT_HOLD + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_COUNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(FAULT_HOLD - 1);

  typedef enum logic [1:0] {
    ST_OK,
    ST_SUSPECT,
    ST_FAULT,
    ST_RECOVER
  } fault_state_t;

  // Channel order: low, mid, high, earth, air, low_temp, selector.
  logic [6:0]    raw_bus;
  logic [6:0]    sync1;
  logic [6:0]    sync2;
  logic [6:0]    stable;
  logic [6:0]    upd;
  logic [DW-1:0] db_cnt [7];
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          repeat_fire;
  logic          inconsistent;
  fault_state_t  state;
  fault_state_t  next_state;
  logic [HW-1:0] hold;
  logic [HW-1:0] next_hold;

  assign raw_bus = {selector_raw, low_temperature_raw, air_humidity_raw, earth_humidity_raw,
                    high_water_level_raw, mid_water_level_raw, low_water_level_raw};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_bus;
      sync2 <= sync1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A channel accepts its new level on the tick that completes the run of differing samples.
  always_comb begin
    upd = '0;
    for (int i = 0; i < 7; i++) begin
      upd[i] = tick && (sync2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < 7; i++) begin
        db_cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < 7; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (upd[i]) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef SELECTOR_REPEAT_EN
  localparam int RPT = 4 * DEBOUNCE_COUNT;
  localparam int RW  = $clog2(RPT + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(RPT - 1);

  logic [RW-1:0] rpt_cnt;

  assign repeat_fire = tick && stable[6] && !upd[6] && (rpt_cnt == RPT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt <= '0;
    end else if (!stable[6] || upd[6]) begin
      rpt_cnt <= '0;
    end else if (tick) begin
      rpt_cnt <= repeat_fire ? '0 : rpt_cnt + 1'b1;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sensor_changed <= 1'b0;
      selector_pulse <= 1'b0;
    end else begin
      sensor_changed <= |upd[5:0];
      selector_pulse <= (upd[6] && sync2[6]) || repeat_fire;
    end
  end

  // Evaluated on the levels held before this tick's debounce updates land.
  assign inconsistent = (stable[2] & ~stable[1]) | (stable[1] & ~stable[0]);

  always_comb begin
    next_state = state;
    next_hold  = hold;
    if (tick) begin
      case (state)
        ST_OK: begin
          if (inconsistent) begin
            next_state = ST_SUSPECT;
            next_hold  = HW'(1);
          end
        end
        ST_SUSPECT: begin
          if (!inconsistent) begin
            next_state = ST_OK;
            next_hold  = '0;
          end else if (hold >= HOLD_LAST) begin
            next_state = ST_FAULT;
            next_hold  = '0;
          end else begin
            next_hold = hold + 1'b1;
          end
        end
        ST_FAULT: begin
          if (!inconsistent) begin
            next_state = ST_RECOVER;
            next_hold  = HW'(1);
          end
        end
        ST_RECOVER: begin
          if (inconsistent) begin
            next_state = ST_FAULT;
            next_hold  = '0;
          end else if (hold >= HOLD_LAST) begin
            next_state = ST_OK;
            next_hold  = '0;
          end else begin
            next_hold = hold + 1'b1;
          end
        end
        default: begin
          next_state = ST_OK;
          next_hold  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_OK;
      hold        <= '0;
      water_fault <= 1'b0;
    end else begin
      state       <= next_state;
      hold        <= next_hold;
      water_fault <= (next_state == ST_FAULT) || (next_state == ST_RECOVER);
    end
  end

  assign low_water_level  = stable[0];
  assign mid_water_level  = stable[1];
  assign high_water_level = stable[2];
  assign earth_humidity   = stable[3];
  assign air_humidity     = stable[4];
  assign low_temperature  = stable[5];

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Bench for sensor_input_conditioner: tick-level behavioural model compared every cycle,
// plus hand-computed checkpoints at known edge counts after reset release.
module tb_sensor_input_conditioner;

  localparam int SD = 4;
  localparam int DC = 3;
  localparam int FH = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic low_raw = 1'b0, mid_raw = 1'b0, high_raw = 1'b0;
  logic earth_raw = 1'b0, air_raw = 1'b0, temp_raw = 1'b0, sel_raw = 1'b0;
  logic low_water_level, mid_water_level, high_water_level;
  logic earth_humidity, air_humidity, low_temperature;
  logic selector_pulse, sensor_changed, water_fault;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;
  int sel_pulses = 0;

  sensor_input_conditioner #(
    .SAMPLE_DIV(SD),
    .DEBOUNCE_COUNT(DC),
    .FAULT_HOLD(FH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .low_water_level_raw(low_raw),
    .mid_water_level_raw(mid_raw),
    .high_water_level_raw(high_raw),
    .earth_humidity_raw(earth_raw),
    .air_humidity_raw(air_raw),
    .low_temperature_raw(temp_raw),
    .selector_raw(sel_raw),
    .low_water_level(low_water_level),
    .mid_water_level(mid_water_level),
    .high_water_level(high_water_level),
    .earth_humidity(earth_humidity),
    .air_humidity(air_humidity),
    .low_temperature(low_temperature),
    .selector_pulse(selector_pulse),
    .sensor_changed(sensor_changed),
    .water_fault(water_fault)
  );

  always #5 clock = ~clock;

  // Behavioural model: raw inputs delayed two edges, sampled every SD-th edge after release.
  int edges = 0;
  logic [6:0] d1 = '0, d2 = '0;
  logic [6:0] m_level = '0;
  int run [7];
  bit m_fault = 1'b0;
  int f_run = 0;
  int sel_ticks = 0;
  bit m_changed = 1'b0, m_pulse = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edges = 0; d1 = '0; d2 = '0; m_level = '0; m_fault = 1'b0; f_run = 0;
      sel_ticks = 0; m_changed = 1'b0; m_pulse = 1'b0;
      for (int i = 0; i < 7; i++) run[i] = 0;
    end else begin
      logic [6:0] syn;
      bit sample, incons, sel_flip;
      syn = d2;
      sample = (edges % SD) == SD - 1;
      incons = (m_level[2] && !m_level[1]) || (m_level[1] && !m_level[0]);
      m_changed = 1'b0;
      m_pulse = 1'b0;
      sel_flip = 1'b0;
      if (sample) begin
        if (incons != m_fault) begin
          f_run++;
          if (f_run == FH) begin m_fault = !m_fault; f_run = 0; end
        end else f_run = 0;
        for (int i = 0; i < 7; i++) begin
          if (syn[i] != m_level[i]) begin
            run[i]++;
            if (run[i] == DC) begin
              m_level[i] = syn[i];
              run[i] = 0;
              if (i < 6) m_changed = 1'b1;
              else begin sel_flip = 1'b1; if (syn[i]) m_pulse = 1'b1; end
            end
          end else run[i] = 0;
        end
`ifdef SELECTOR_REPEAT_EN
        if (m_level[6] && !sel_flip) begin
          sel_ticks++;
          if (sel_ticks % (4 * DC) == 0) m_pulse = 1'b1;
        end else sel_ticks = 0;
`endif
      end
      d2 = d1;
      d1 = {sel_raw, temp_raw, air_raw, earth_raw, high_raw, mid_raw, low_raw};
      edges++;
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_low"}, low_water_level, 1'b0);
    checkOutput({tag, "_mid"}, mid_water_level, 1'b0);
    checkOutput({tag, "_high"}, high_water_level, 1'b0);
    checkOutput({tag, "_earth"}, earth_humidity, 1'b0);
    checkOutput({tag, "_air"}, air_humidity, 1'b0);
    checkOutput({tag, "_temp"}, low_temperature, 1'b0);
    checkOutput({tag, "_sel"}, selector_pulse, 1'b0);
    checkOutput({tag, "_chg"}, sensor_changed, 1'b0);
    checkOutput({tag, "_wf"}, water_fault, 1'b0);
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("m_low", low_water_level, m_level[0]);
      checkOutput("m_mid", mid_water_level, m_level[1]);
      checkOutput("m_high", high_water_level, m_level[2]);
      checkOutput("m_earth", earth_humidity, m_level[3]);
      checkOutput("m_air", air_humidity, m_level[4]);
      checkOutput("m_temp", low_temperature, m_level[5]);
      checkOutput("m_sel_pulse", selector_pulse, m_pulse);
      checkOutput("m_changed", sensor_changed, m_changed);
      checkOutput("m_fault", water_fault, m_fault);
      if (selector_pulse) sel_pulses++;
    end
  end

  task automatic applyStimulus(input int at_edge);
    while (edges < at_edge) @(negedge clock);
  endtask

  initial begin
    int exp_pulses;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    check_en = 1'b1;

    applyStimulus(8);
    checkAllZero("idle");
    earth_raw = 1'b1;
    applyStimulus(19);
    checkOutput("earth_before_accept", earth_humidity, 1'b0);
    applyStimulus(20);
    checkOutput("earth_accept", earth_humidity, 1'b1);
    checkOutput("earth_strobe", sensor_changed, 1'b1);
    applyStimulus(21);
    checkOutput("earth_strobe_end", sensor_changed, 1'b0);

    low_raw = 1'b1;
    applyStimulus(29);
    low_raw = 1'b0;
    applyStimulus(41);
    checkOutput("glitch_low", low_water_level, 1'b0);

    low_raw = 1'b1;
    high_raw = 1'b1;
    applyStimulus(52);
    checkOutput("lh_low", low_water_level, 1'b1);
    checkOutput("lh_high", high_water_level, 1'b1);
    checkOutput("lh_strobe", sensor_changed, 1'b1);
    applyStimulus(59);
    checkOutput("fault_not_yet", water_fault, 1'b0);
    applyStimulus(60);
    checkOutput("fault_set", water_fault, 1'b1);
    mid_raw = 1'b1;
    applyStimulus(79);
    checkOutput("fault_recovering", water_fault, 1'b1);
    applyStimulus(80);
    checkOutput("fault_cleared", water_fault, 1'b0);

    mid_raw = 1'b0;
    applyStimulus(100);
    checkOutput("fault_again", water_fault, 1'b1);
    mid_raw = 1'b1;
    applyStimulus(108);
    air_raw = 1'b1;
    applyStimulus(117);
    checkOutput("in_recover", water_fault, 1'b1);
    #2 reset_n = 1'b0;
    #1 checkAllZero("async_rst");
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;

    applyStimulus(11);
    checkOutput("air_restart_pending", air_humidity, 1'b0);
    applyStimulus(12);
    checkOutput("air_restart_done", air_humidity, 1'b1);
    checkOutput("restart_strobe", sensor_changed, 1'b1);
    checkOutput("restart_no_fault", water_fault, 1'b0);

    applyStimulus(16);
    sel_pulses = 0;
    sel_raw = 1'b1;
    applyStimulus(27);
    checkOutput("sel_before", selector_pulse, 1'b0);
    applyStimulus(28);
    checkOutput("sel_press", selector_pulse, 1'b1);
    applyStimulus(176);
    sel_raw = 1'b0;
    applyStimulus(230);
`ifdef SELECTOR_REPEAT_EN
    exp_pulses = 4;
`else
    exp_pulses = 1;
`endif
    checkCount("sel_pulse_count", sel_pulses, exp_pulses);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
